// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-queue slice: data width and launch FSM states.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Host write port plus transmitter launch handshake for uart_tx_queue.
// UART_TXQ_FLUSH_EN adds the flush strobe.
interface uart_tx_queue_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
);

  logic                      wr_en;
  logic [UART_DATA_W-1:0]    wr_data;
  logic                      full;
  logic                      empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      tx_start;
  logic [UART_DATA_W-1:0]    tx_data;
  logic                      tx_busy;
  logic                      timeout_err;
`ifdef UART_TXQ_FLUSH_EN
  logic                      flush;
`endif

  modport slave (
    input  wr_en, wr_data, tx_busy,
`ifdef UART_TXQ_FLUSH_EN
    input  flush,
`endif
    output full, empty, count, overflow, tx_start, tx_data, timeout_err
  );

  modport master (
    output wr_en, wr_data, tx_busy,
`ifdef UART_TXQ_FLUSH_EN
    output flush,
`endif
    input  full, empty, count, overflow, tx_start, tx_data, timeout_err
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// DEPTH x 8 synchronous FIFO with registered count/full/empty and sticky overflow.
// clr empties the FIFO and outranks a simultaneous write.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [UART_DATA_W-1:0]    wr_data,
  input  logic                      rd_en,
  output logic [UART_DATA_W-1:0]    rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic             wr_ok;
  logic             pop;

  always_comb begin
    wr_ok      = wr_en && !full_q && !clr;
    pop        = rd_en && !empty_q && !clr;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // full is the pre-edge value, so a same-edge pop never rescues the write
      if (wr_en && full_q) overflow_d = 1'b1;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch controller feeding the UART transmitter.
// Optional UART_TXQ_FLUSH_EN adds a flush input that empties the queue.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst,
  uart_tx_queue_if.slave bus
);

  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  logic                      flush_i;
  logic                      pop;
  logic [UART_DATA_W-1:0]    head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_ovf;
  logic [cnt_w(DEPTH)-1:0]   fifo_count;

  txq_state_e             state_q, state_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   timeout_err_q, timeout_err_d;

`ifdef UART_TXQ_FLUSH_EN
  assign flush_i = bus.flush;
`else
  assign flush_i = 1'b0;
`endif

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_i),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  always_comb begin
    state_d       = state_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    tmo_d         = tmo_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy && !flush_i) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a frame already handed to the transmitter still runs to completion
    if (flush_i && (state_q == LAUNCH || state_q == WAIT_BUSY)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      tmo_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.full        = fifo_full;
  assign bus.empty       = fifo_empty;
  assign bus.count       = fifo_count;
  assign bus.overflow    = fifo_ovf;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: queue-based reference model, transmitter model with
// loopback capture, directed scenarios. Flush scenario runs when UART_TXQ_FLUSH_EN is defined.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transmitter: busy for busy_len cycles starting the cycle after tx_start
  localparam int XM_NORMAL = 0, XM_HOLD = 1, XM_DEAD = 2;
  int         xm_mode  = XM_NORMAL;
  int         busy_len = 4;
  int         busy_cnt = 0;
  int         n_starts = 0;
  logic [7:0] rx_q[$];

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) begin
        bus.tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        bus.tx_busy = 1'b0;
      end
      if (bus.tx_start === 1'b1) begin
        n_starts++;
        rx_q.push_back(bus.tx_data);
        if (xm_mode == XM_NORMAL) busy_cnt = busy_len;
      end
      if (xm_mode == XM_HOLD) bus.tx_busy = 1'b1;
    end
  end

  // reference model: byte queue plus the life cycle of the frame last handed out
  localparam int F_FREE = 0, F_LAUNCHED = 1, F_AWAIT = 2, F_INFRAME = 3;
  logic [7:0] m_q[$];
  bit         m_ovf, m_terr, m_start, chk_en;
  logic [7:0] m_data;
  int         m_phase, m_old, m_waited, m_pre;
  bit         m_launch, m_fl;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 0; m_terr = 0; m_start = 0; m_data = 8'h00;
      m_phase = F_FREE; m_waited = 0;
      chk_en = 1;
    end else begin
`ifdef UART_TXQ_FLUSH_EN
      m_fl = bus.flush;
`else
      m_fl = 0;
`endif
      m_pre    = m_q.size();
      m_old    = m_phase;
      m_launch = (m_old == F_FREE) && (m_pre > 0) && !bus.tx_busy && !m_fl;
      case (m_old)
        F_LAUNCHED: begin m_phase = F_AWAIT; m_waited = 0; end
        F_AWAIT: begin
          if (bus.tx_busy) m_phase = F_INFRAME;
          else begin
            m_waited++;
            if (m_waited == BUSY_TIMEOUT - 1) begin m_terr = 1; m_phase = F_FREE; end
          end
        end
        F_INFRAME: if (!bus.tx_busy) m_phase = F_FREE;
        default: ;
      endcase
      if (m_fl && (m_old == F_LAUNCHED || m_old == F_AWAIT)) m_phase = F_FREE;
      m_start = m_launch;
      if (m_launch) begin
        m_data  = m_q.pop_front();
        m_phase = F_LAUNCHED;
      end
      if (m_fl) m_q.delete();
      else if (bus.wr_en) begin
        if (m_pre == DEPTH) m_ovf = 1;
        else m_q.push_back(bus.wr_data);
      end
    end
  end

  int peak    = 0;
  bit peak_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",       bus.count,       m_q.size());
      chk("empty",       bus.empty,       m_q.size() == 0);
      chk("full",        bus.full,        m_q.size() == DEPTH);
      chk("overflow",    bus.overflow,    m_ovf);
      chk("timeout_err", bus.timeout_err, m_terr);
      chk("tx_start",    bus.tx_start,    m_start);
      chk("tx_data",     bus.tx_data,     m_data);
      if (peak_en && int'(bus.count) > peak) peak = int'(bus.count);
    end
  end

  task automatic wr_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    bit ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (bus.empty === 1'b1 && bus.tx_busy === 1'b0 && m_phase == F_FREE && busy_cnt == 0) begin
        ok = 1;
        break;
      end
    end
    chk({"idle_", nm}, ok, 1);
    tick();
  endtask

  task automatic wait_busy(input string nm);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.tx_busy === 1'b1) begin ok = 1; break; end
      tick();
    end
    chk({"busy_seen_", nm}, ok, 1);
  endtask

  task automatic chk_rx(input string nm, input int idx, input logic [7:0] exp);
    if (idx < rx_q.size()) chk(nm, rx_q[idx], exp);
    else chk({nm, "_missing"}, 32'hFFFF_FFFF, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  logic [7:0] burst [5];
  logic [7:0] v;
  int         wr_cyc, s_cyc, t_cyc, ns;
  bit         found;

  initial begin
    burst = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h55};
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
`ifdef UART_TXQ_FLUSH_EN
    bus.flush = 1'b0;
`endif
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("reset_count", bus.count, 0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_tx_data", bus.tx_data, 8'h00);

    // single byte
    rx_q.delete();
    wr_cyc = cyc;
    wr_byte(8'hA5);
    found = 0;
    s_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_start === 1'b1) begin found = 1; s_cyc = cyc; break; end
      tick();
    end
    chk("single_found", found, 1);
    chk("single_delay", s_cyc - wr_cyc, 2);
    chk("single_tx_data", bus.tx_data, 8'hA5);
    tick();
    chk("single_width", bus.tx_start, 0);
    wait_idle("single", 200);
    chk("single_count", bus.count, 0);
    chk("single_rx_n", rx_q.size(), 1);
    chk_rx("single_rx", 0, 8'hA5);

    // burst
    rx_q.delete();
    peak = 0;
    peak_en = 1;
    for (int i = 0; i < 5; i++) wr_byte(burst[i]);
    wait_idle("burst", 300);
    peak_en = 0;
    chk("burst_peak_4_or_5", (peak == 4 || peak == 5), 1);
    chk("burst_rx_n", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) chk_rx("burst_rx", i, burst[i]);

    // full / overflow
    xm_mode = XM_HOLD;
    tick();
    tick();
    rx_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(i);
      wr_byte(v);
    end
    chk("ovf_full", bus.full, 1);
    chk("ovf_not_yet", bus.overflow, 0);
    wr_byte(8'h10);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_count", bus.count, 16);
    xm_mode = XM_NORMAL;
    wait_idle("ovf", 2000);
    chk("ovf_rx_n", rx_q.size(), 16);
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'(i);
      chk_rx("ovf_rx", i, v);
    end

    // timeout
    xm_mode = XM_DEAD;
    rx_q.delete();
    wr_byte(8'h3C);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_start === 1'b1) begin found = 1; s_cyc = cyc; break; end
      tick();
    end
    chk("tmo_start_found", found, 1);
    found = 0;
    t_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.timeout_err === 1'b1) begin found = 1; t_cyc = cyc; break; end
    end
    chk("tmo_err_found", found, 1);
    chk("tmo_delay", t_cyc - s_cyc, BUSY_TIMEOUT);
    xm_mode = XM_NORMAL;
    tick();
    rx_q.delete();
    wr_byte(8'h55);
    wait_idle("tmo_next", 200);
    chk("tmo_next_rx_n", rx_q.size(), 1);
    chk_rx("tmo_next_rx", 0, 8'h55);

    // reset during WAIT_DONE of the first of three bytes
    busy_len = 6;
    wr_byte(8'hC1);
    wr_byte(8'hC2);
    wr_byte(8'hC3);
    wait_busy("rst");
    tick();
    rst = 1'b1;
    tick();
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    rst = 1'b0;
    ns = n_starts;
    repeat (40) tick();
    chk("rst_no_launch", n_starts - ns, 0);

`ifdef UART_TXQ_FLUSH_EN
    // flush during WAIT_DONE with a competing write
    rx_q.delete();
    wr_byte(8'hD1);
    wr_byte(8'hD2);
    wr_byte(8'hD3);
    wr_byte(8'hD4);
    wait_busy("flush");
    tick();
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1);
    chk("flush_overflow", bus.overflow, 0);
    ns = n_starts;
    repeat (40) tick();
    chk("flush_no_launch", n_starts - ns, 0);
    chk("flush_rx_n", rx_q.size(), 1);
    chk_rx("flush_rx", 0, 8'hD1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
